// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and the load/store unit.
// One transaction in flight; data has priority with a bounded streak, flush discards fetches, timeout errors.
module mem_port_arbiter #(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        imem_valid,
  output logic        imem_error,
  input  logic        flush,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_valid,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        mem_error
);

  localparam int unsigned STREAK_W = $clog2(DATA_STREAK_MAX + 1);
  localparam int unsigned TIMER_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                discard_q, discard_d;

  logic [31:0] imem_data_d, dmem_rdata_d, mem_addr_d, mem_wdata_d;
  logic        imem_valid_d, imem_error_d, dmem_valid_d, dmem_error_d;
  logic        mem_req_d, mem_we_d;
  logic [3:0]  mem_be_d;

  logic grant_i, grant_d, streak_full, timeout, kill;

  // Next-state, grant and response logic
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    timer_d      = timer_q;
    discard_d    = discard_q;
    imem_data_d  = imem_data;
    imem_valid_d = 1'b0;
    imem_error_d = imem_error;
    dmem_rdata_d = dmem_rdata;
    dmem_valid_d = 1'b0;
    dmem_error_d = dmem_error;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_be_d     = mem_be;

    streak_full = (streak_q == STREAK_W'(DATA_STREAK_MAX));
    timeout     = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    kill        = discard_q | flush;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        grant_i   = imem_read & ~flush & (~dmem_req | streak_full);
        grant_d   = dmem_req & ~grant_i;
        if (grant_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = imem_addr;
          mem_wdata_d = 32'h0;
          mem_be_d    = 4'hF;
          streak_d    = '0;
          timer_d     = '0;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dmem_we;
          mem_addr_d  = dmem_addr;
          mem_wdata_d = dmem_wdata;
          mem_be_d    = dmem_be;
          timer_d     = '0;
          if (!imem_read)       streak_d = '0;
          else if (!streak_full) streak_d = streak_q + STREAK_W'(1);
        end
      end
      BUSY_I: begin
        timer_d = timer_q + TIMER_W'(1);
        if (flush) discard_d = 1'b1;
        if (mem_valid || timeout) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!kill) begin
            imem_valid_d = 1'b1;
            imem_data_d  = mem_valid ? mem_rdata : 32'h0;
            imem_error_d = mem_valid ? mem_error : 1'b1;
          end
        end
      end
      BUSY_D: begin
        timer_d = timer_q + TIMER_W'(1);
        if (mem_valid || timeout) begin
          state_d      = IDLE;
          dmem_valid_d = 1'b1;
          dmem_rdata_d = mem_valid ? mem_rdata : 32'h0;
          dmem_error_d = mem_valid ? mem_error : 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      timer_q    <= '0;
      discard_q  <= 1'b0;
      imem_data  <= 32'h0;
      imem_valid <= 1'b0;
      imem_error <= 1'b0;
      dmem_rdata <= 32'h0;
      dmem_valid <= 1'b0;
      dmem_error <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'h0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      timer_q    <= timer_d;
      discard_q  <= discard_d;
      imem_data  <= imem_data_d;
      imem_valid <= imem_valid_d;
      imem_error <= imem_error_d;
      dmem_rdata <= dmem_rdata_d;
      dmem_valid <= dmem_valid_d;
      dmem_error <= dmem_error_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_be     <= mem_be_d;
    end
  end

endmodule
